csum_frame_arbiter: RTL

//   Shares one 32-bit XOR-accumulate checksum engine between NUM_REQ requester streams.

---
 rtl/csum_frame_arbiter.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/csum_frame_arbiter.sv
// Round-robin arbiter sharing one XOR-accumulate checksum engine between NUM_REQ streams.
// One frame per grant; each closed frame yields a result record behind a valid/ready handshake.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | no grant held; pick first valid requester at/after rr_ptr
// ST_BUSY   | granted requester streams beats into the accumulator
// ST_RESULT | result record presented, waiting for res_ready_i
module csum_frame_arbiter #(
    parameter int          NUM_REQ   = 4,
    parameter int          MAX_BEATS = 256,
    parameter logic [31:0] SEED      = 32'hFFFFFFFF,
    localparam int         SRC_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int         LEN_W     = $clog2(MAX_BEATS + 1)
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [NUM_REQ-1:0]     req_valid_i,
    input  logic [32*NUM_REQ-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]     req_last_i,
    output logic [NUM_REQ-1:0]     req_ready_o,
    output logic                   res_valid_o,
    input  logic                   res_ready_i,
    output logic [31:0]            res_data_o,
    output logic [SRC_W-1:0]       res_src_o,
    output logic [LEN_W-1:0]       res_len_o,
    output logic                   res_err_o,
    output logic                   busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_RESULT
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [SRC_W-1:0]   grant;
    logic [SRC_W-1:0]   rr_ptr;
    logic [SRC_W-1:0]   arb_idx;
    logic [SRC_W-1:0]   grant_inc;
    logic               arb_found;
    logic [SRC_W:0]     arb_sum;
    logic [2*NUM_REQ-1:0] valid_dbl;
    logic [2*NUM_REQ-1:0] valid_rot;
    logic [31:0]        acc;
    logic [31:0]        beat_data;
    logic               beat_valid;
    logic               beat_last;
    logic               beat_acc;
    logic               hit_max;
    logic               frame_close;
    logic [LEN_W-1:0]   beat_cnt;
    logic [LEN_W-1:0]   beat_cnt_inc;

    // Rotate the request vector so that rr_ptr lands at bit 0, then take the first set bit.
    always_comb begin
        valid_dbl = {req_valid_i, req_valid_i};
        valid_rot = valid_dbl >> rr_ptr;
        arb_found = 1'b0;
        arb_idx   = '0;
        arb_sum   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!arb_found && valid_rot[i]) begin
                arb_found = 1'b1;
                arb_sum   = {1'b0, rr_ptr} + (SRC_W+1)'(i);
                if (arb_sum >= (SRC_W+1)'(NUM_REQ)) begin
                    arb_sum = arb_sum - (SRC_W+1)'(NUM_REQ);
                end
                arb_idx = arb_sum[SRC_W-1:0];
            end
        end
    end

    always_comb begin
        beat_data  = '0;
        beat_valid = 1'b0;
        beat_last  = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (grant == SRC_W'(k)) begin
                beat_data  = req_data_i[32*k +: 32];
                beat_valid = req_valid_i[k];
                beat_last  = req_last_i[k];
            end
        end
    end

    always_comb begin
        req_ready_o = '0;
        if (state == ST_BUSY) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                req_ready_o[k] = (grant == SRC_W'(k));
            end
        end
    end

    assign beat_acc     = (state == ST_BUSY) && beat_valid;
    assign beat_cnt_inc = beat_cnt + 1'b1;
    assign hit_max      = (beat_cnt_inc == LEN_W'(MAX_BEATS));
    assign frame_close  = beat_acc && (beat_last || hit_max);
    assign grant_inc    = (grant == SRC_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;

    assign res_valid_o = (state == ST_RESULT);
    assign busy_o      = (state != ST_IDLE);

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (arb_found)   state_nxt = ST_BUSY;
            ST_BUSY:   if (frame_close) state_nxt = ST_RESULT;
            ST_RESULT: if (res_ready_i) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            grant      <= '0;
            rr_ptr     <= '0;
            acc        <= SEED;
            beat_cnt   <= '0;
            res_data_o <= '0;
            res_src_o  <= '0;
            res_len_o  <= '0;
            res_err_o  <= 1'b0;
        end else begin
            if ((state == ST_IDLE) && arb_found) begin
                grant <= arb_idx;
            end
            if (beat_acc) begin
                if (frame_close) begin
                    res_data_o <= acc ^ beat_data;
                    res_len_o  <= beat_cnt_inc;
                    res_src_o  <= grant;
                    res_err_o  <= ~beat_last;
                    acc        <= SEED;
                    beat_cnt   <= '0;
                end else begin
                    acc      <= acc ^ beat_data;
                    beat_cnt <= beat_cnt_inc;
                end
            end
            if ((state == ST_RESULT) && res_ready_i) begin
                rr_ptr <= grant_inc;
            end
        end
    end

endmodule
